// File: rtl/lcms_dac_serial_rx.sv
// lcms_dac_serial_rx
// Receive-side model of the two DAC serial links (shared DAC_SCLK, per-link
// SYNC/DIN). The links are oversampled on dac_sm_clk and decoded as 16-bit,
// MSB-first frames. Data words land in a 16-entry shadow register file.
// Control words and framing errors are reported.
//
// Strobe semantics: wr1_valid, wr2_valid, ctrl_valid[n] and err_pulse[n] are
// single-cycle pulses with no back-pressure. The value registers that go with
// each pulse are wr_ch, wr_dataN and ctrl_word. They update in the same cycle
// as the pulse and hold their value until the next commit.
//
// Ports:
//   dac_sm_clk, reset         system clock, synchronous active-high reset
//   DAC_SCLK                  shared serial clock, data valid on falling edge
//   DAC1_SYNC/DIN, DAC2_SYNC/DIN  per-link frame strobe (active-low) and data
//   wr1_valid, wr2_valid      data-word commit pulses
//   wr_ch                     {link2 ch, link1 ch} of last data commit per link
//   wr_data1, wr_data2        last committed data per link
//   ctrl_valid, ctrl_word     control-word pulse per link, last control payload
//   err_pulse, err_sticky     framing error pulse / sticky flag per link
//   err_clr                   clears err_sticky (a coincident new error wins)
//   rd_addr, rd_data          shadow readback, one-cycle registered latency
//   frame_cnt1, frame_cnt2    committed frames per link, wrapping
module lcms_dac_serial_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 16
) (
  input  logic        dac_sm_clk,
  input  logic        reset,
  input  logic        DAC_SCLK,
  input  logic        DAC1_SYNC,
  input  logic        DAC1_DIN,
  input  logic        DAC2_SYNC,
  input  logic        DAC2_DIN,
  output logic        wr1_valid,
  output logic        wr2_valid,
  output logic [5:0]  wr_ch,
  output logic [11:0] wr_data1,
  output logic [11:0] wr_data2,
  output logic [1:0]  ctrl_valid,
  output logic [14:0] ctrl_word,
  output logic [1:0]  err_pulse,
  output logic [1:0]  err_sticky,
  input  logic        err_clr,
  input  logic [3:0]  rd_addr,
  output logic [11:0] rd_data,
  output logic [15:0] frame_cnt1,
  output logic [15:0] frame_cnt2
);

  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  typedef enum logic [1:0] {WAIT_HIGH, IDLE, SHIFT, DONE} state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sr, sync1_sr, din1_sr, sync2_sr, din2_sr;
  // The priming chain fills with ones after reset. Once it is full, the data
  // synchronizers hold only real samples and no longer hold reset values.
  logic [SYNC_STAGES-1:0] prime_sr;
  logic                   sclk_d;
  logic [1:0]             sync_d;

  always_ff @(posedge dac_sm_clk) begin
    if (reset) begin
      sclk_sr  <= '1;
      sync1_sr <= '1;
      sync2_sr <= '1;
      din1_sr  <= '0;
      din2_sr  <= '0;
      prime_sr <= '0;
      sclk_d   <= 1'b1;
      sync_d   <= 2'b11;
    end else begin
      sclk_sr[0]  <= DAC_SCLK;
      sync1_sr[0] <= DAC1_SYNC;
      sync2_sr[0] <= DAC2_SYNC;
      din1_sr[0]  <= DAC1_DIN;
      din2_sr[0]  <= DAC2_DIN;
      prime_sr[0] <= 1'b1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_sr[i]  <= sclk_sr[i-1];
        sync1_sr[i] <= sync1_sr[i-1];
        sync2_sr[i] <= sync2_sr[i-1];
        din1_sr[i]  <= din1_sr[i-1];
        din2_sr[i]  <= din2_sr[i-1];
        prime_sr[i] <= prime_sr[i-1];
      end
      sclk_d <= sclk_sr[SYNC_STAGES-1];
      sync_d <= {sync2_sr[SYNC_STAGES-1], sync1_sr[SYNC_STAGES-1]};
    end
  end

  logic       sclk_s, sclk_fall, primed;
  logic [1:0] sync_s, din_s, sync_fall, sync_rise;

  assign sclk_s    = sclk_sr[SYNC_STAGES-1];
  assign sclk_fall = sclk_d & ~sclk_s;
  assign primed    = prime_sr[SYNC_STAGES-1];
  assign sync_s    = {sync2_sr[SYNC_STAGES-1], sync1_sr[SYNC_STAGES-1]};
  assign din_s     = {din2_sr[SYNC_STAGES-1], din1_sr[SYNC_STAGES-1]};
  assign sync_fall = sync_d & ~sync_s;
  assign sync_rise = ~sync_d & sync_s;

  // ---------------------------------------------------------------------------
  // Per-link frame FSMs (index 0 = DAC1, 1 = DAC2)
  // ---------------------------------------------------------------------------
  state_t      state     [2];
  state_t      state_nxt [2];
  logic [14:0] shreg     [2];
  logic [14:0] shreg_nxt [2];
  logic [3:0]  cnt       [2];
  logic [3:0]  cnt_nxt   [2];
  logic [15:0] frame     [2];
  logic [1:0]  ovr, ovr_nxt, commit, err;

  always_ff @(posedge dac_sm_clk) begin
    if (reset) begin
      for (int l = 0; l < 2; l++) begin
        state[l] <= WAIT_HIGH;
        shreg[l] <= '0;
        cnt[l]   <= '0;
      end
      ovr <= '0;
    end else begin
      for (int l = 0; l < 2; l++) begin
        state[l] <= state_nxt[l];
        shreg[l] <= shreg_nxt[l];
        cnt[l]   <= cnt_nxt[l];
      end
      ovr <= ovr_nxt;
    end
  end

  always_comb begin
    for (int l = 0; l < 2; l++) begin
      state_nxt[l] = state[l];
      shreg_nxt[l] = shreg[l];
      cnt_nxt[l]   = cnt[l];
      ovr_nxt[l]   = ovr[l];
      commit[l]    = 1'b0;
      err[l]       = 1'b0;
      // Frame word as it stands with the current DIN shifted in. This is the
      // committed word when the last bit arrives.
      frame[l]     = {shreg[l], din_s[l]};
      case (state[l])
        // Leave only on a genuine high level. This avoids treating SYNC that
        // was already low across reset as a new frame start.
        WAIT_HIGH: if (primed && sync_s[l]) state_nxt[l] = IDLE;
        IDLE: begin
          if (sync_fall[l]) begin
            shreg_nxt[l] = '0;
            cnt_nxt[l]   = '0;
            ovr_nxt[l]   = 1'b0;
            state_nxt[l] = SHIFT;
          end
        end
        SHIFT: begin
          if (sync_rise[l]) begin
            err[l]       = (cnt[l] != 4'd0);
            state_nxt[l] = IDLE;
          end else if (sclk_fall) begin
            shreg_nxt[l] = frame[l][14:0];
            cnt_nxt[l]   = cnt[l] + 4'd1;
            if (cnt[l] == LAST_BIT) begin
              commit[l]    = 1'b1;
              state_nxt[l] = DONE;
            end
          end
        end
        DONE: begin
          if (sync_rise[l]) begin
            err[l]       = ovr[l];
            state_nxt[l] = IDLE;
          end else if (sclk_fall) begin
            ovr_nxt[l] = 1'b1;
          end
        end
        default: state_nxt[l] = WAIT_HIGH;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Commit, decode, shadow file and status
  // ---------------------------------------------------------------------------
  logic [11:0] shadow [16];

  always_ff @(posedge dac_sm_clk) begin
    if (reset) begin
      wr1_valid  <= 1'b0;
      wr2_valid  <= 1'b0;
      wr_ch      <= '0;
      wr_data1   <= '0;
      wr_data2   <= '0;
      ctrl_valid <= '0;
      ctrl_word  <= '0;
      err_pulse  <= '0;
      err_sticky <= '0;
      rd_data    <= '0;
      frame_cnt1 <= '0;
      frame_cnt2 <= '0;
      for (int i = 0; i < 16; i++) shadow[i] <= '0;
    end else begin
      wr1_valid  <= commit[0] & ~frame[0][15];
      wr2_valid  <= commit[1] & ~frame[1][15];
      ctrl_valid <= commit & {frame[1][15], frame[0][15]};
      err_pulse  <= err;
      // A new error takes priority over a coincident clear.
      err_sticky <= err | (err_sticky & {2{~err_clr}});
      // The read uses the pre-write value on a same-address collision.
      rd_data    <= shadow[rd_addr];

      if (commit[0]) begin
        frame_cnt1 <= frame_cnt1 + 16'd1;
        if (!frame[0][15]) begin
          wr_ch[2:0]                        <= frame[0][14:12];
          wr_data1                          <= frame[0][11:0];
          shadow[{1'b0, frame[0][14:12]}]   <= frame[0][11:0];
        end
      end
      if (commit[1]) begin
        frame_cnt2 <= frame_cnt2 + 16'd1;
        if (!frame[1][15]) begin
          wr_ch[5:3]                        <= frame[1][14:12];
          wr_data2                          <= frame[1][11:0];
          shadow[{1'b1, frame[1][14:12]}]   <= frame[1][11:0];
        end
      end

      // Link 1 takes priority when both links deliver a control word together.
      if (commit[0] && frame[0][15])      ctrl_word <= frame[0][14:0];
      else if (commit[1] && frame[1][15]) ctrl_word <= frame[1][14:0];
    end
  end

endmodule

// File: tb/tb_lcms_dac_serial_rx.sv
// Testbench for lcms_dac_serial_rx: directed frames from the test plan, then
// randomized frames on one or both links. A frame-level reference model
// predicts the shadow file, counters, decoded words and error flags.
module tb_lcms_dac_serial_rx;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        DAC_SCLK, DAC1_SYNC, DAC1_DIN, DAC2_SYNC, DAC2_DIN;
  logic        wr1_valid, wr2_valid, err_clr;
  logic [5:0]  wr_ch;
  logic [11:0] wr_data1, wr_data2, rd_data;
  logic [1:0]  ctrl_valid, err_pulse, err_sticky;
  logic [14:0] ctrl_word;
  logic [3:0]  rd_addr;
  logic [15:0] frame_cnt1, frame_cnt2;

  lcms_dac_serial_rx #(.SYNC_STAGES(2), .FRAME_BITS(16)) dut (
    .dac_sm_clk (clk),
    .reset      (reset),
    .DAC_SCLK   (DAC_SCLK),
    .DAC1_SYNC  (DAC1_SYNC),
    .DAC1_DIN   (DAC1_DIN),
    .DAC2_SYNC  (DAC2_SYNC),
    .DAC2_DIN   (DAC2_DIN),
    .wr1_valid  (wr1_valid),
    .wr2_valid  (wr2_valid),
    .wr_ch      (wr_ch),
    .wr_data1   (wr_data1),
    .wr_data2   (wr_data2),
    .ctrl_valid (ctrl_valid),
    .ctrl_word  (ctrl_word),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .err_clr    (err_clr),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frame_cnt1 (frame_cnt1),
    .frame_cnt2 (frame_cnt2)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // pulse monitors (only this block writes them)
  int m_wr1 = 0, m_wr2 = 0, m_both = 0, m_ctl1 = 0, m_ctl2 = 0, m_err1 = 0, m_err2 = 0;
  always @(negedge clk) begin
    if (wr1_valid) m_wr1++;
    if (wr2_valid) m_wr2++;
    if (wr1_valid && wr2_valid) m_both++;
    if (ctrl_valid[0]) m_ctl1++;
    if (ctrl_valid[1]) m_ctl2++;
    if (err_pulse[0]) m_err1++;
    if (err_pulse[1]) m_err2++;
  end

  // reference model state
  logic [11:0] exp_shadow [16];
  logic [15:0] exp_cnt1, exp_cnt2;
  logic [2:0]  exp_ch1, exp_ch2;
  logic [11:0] exp_d1, exp_d2;
  logic [14:0] exp_ctrl;
  logic [1:0]  exp_sticky;
  logic [11:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) exp_shadow[i] = '0;
    exp_cnt1 = 0; exp_cnt2 = 0; exp_ch1 = 0; exp_ch2 = 0;
    exp_d1 = 0; exp_d2 = 0; exp_ctrl = 0; exp_sticky = 0;
  endtask

  // Frame-level rule: n falling edges while SYNC low, then SYNC high.
  // 16 or more edges commit the word; 1..15 or more than 16 edges is an error.
  task automatic model_frame(input int link, input logic [15:0] w, input int n);
    if (n >= 16) begin
      if (link == 0) exp_cnt1++; else exp_cnt2++;
      if (w[15]) exp_ctrl = w[14:0];
      else begin
        exp_shadow[link*8 + int'(w[14:12])] = w[11:0];
        if (link == 0) begin exp_ch1 = w[14:12]; exp_d1 = w[11:0]; end
        else begin exp_ch2 = w[14:12]; exp_d2 = w[11:0]; end
      end
    end
    if ((n >= 1 && n <= 15) || n > 16) exp_sticky[link] = 1'b1;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // one SCLK period: data set while high, sampled on the falling edge
  task automatic sclk_bit(input logic b1, input logic b2, input bit lat_chk);
    DAC1_DIN = b1;
    DAC2_DIN = b2;
    repeat (2) @(negedge clk);
    DAC_SCLK = 1'b0;
    if (lat_chk) begin
      @(posedge clk); #1;
      check("lat_edge1", {31'd0, wr1_valid}, 32'd0);
      @(posedge clk); #1;
      check("lat_edge2", {31'd0, wr1_valid}, 32'd0);
      @(posedge clk); #1;
      check("lat_edge3", {31'd0, wr1_valid}, 32'd1);
      @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
    DAC_SCLK = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_regs();
    check("frame_cnt1", {16'd0, frame_cnt1}, {16'd0, exp_cnt1});
    check("frame_cnt2", {16'd0, frame_cnt2}, {16'd0, exp_cnt2});
    check("wr_ch", {26'd0, wr_ch}, {26'd0, exp_ch2, exp_ch1});
    check("wr_data1", {20'd0, wr_data1}, {20'd0, exp_d1});
    check("wr_data2", {20'd0, wr_data2}, {20'd0, exp_d2});
    check("ctrl_word", {17'd0, ctrl_word}, {17'd0, exp_ctrl});
    check("err_sticky", {30'd0, err_sticky}, {30'd0, exp_sticky});
  endtask

  // full frame on the enabled links, then model update and pulse/register checks
  task automatic run_frame(input bit en1, input logic [15:0] w1, input bit en2,
                           input logic [15:0] w2, input int n, input bit lat_chk);
    int s_wr1, s_wr2, s_both, s_c1, s_c2, s_e1, s_e2;
    logic b1, b2;
    s_wr1 = m_wr1; s_wr2 = m_wr2; s_both = m_both;
    s_c1 = m_ctl1; s_c2 = m_ctl2; s_e1 = m_err1; s_e2 = m_err2;
    @(negedge clk);
    if (en1) DAC1_SYNC = 1'b0;
    if (en2) DAC2_SYNC = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      b1 = (i < 16) ? w1[15-i] : 1'($urandom);
      b2 = (i < 16) ? w2[15-i] : 1'($urandom);
      sclk_bit(b1, b2, lat_chk && (i == 15));
    end
    repeat (2) @(negedge clk);
    DAC1_SYNC = 1'b1;
    DAC2_SYNC = 1'b1;
    repeat (6) @(negedge clk);
    if (en2) model_frame(1, w2, n);
    if (en1) model_frame(0, w1, n);
    check("wr1_pulses", m_wr1 - s_wr1, (en1 && n >= 16 && !w1[15]) ? 1 : 0);
    check("wr2_pulses", m_wr2 - s_wr2, (en2 && n >= 16 && !w2[15]) ? 1 : 0);
    check("ctl1_pulses", m_ctl1 - s_c1, (en1 && n >= 16 && w1[15]) ? 1 : 0);
    check("ctl2_pulses", m_ctl2 - s_c2, (en2 && n >= 16 && w2[15]) ? 1 : 0);
    check("err1_pulses", m_err1 - s_e1, (en1 && ((n >= 1 && n <= 15) || n > 16)) ? 1 : 0);
    check("err2_pulses", m_err2 - s_e2, (en2 && ((n >= 1 && n <= 15) || n > 16)) ? 1 : 0);
    if (en1 && en2 && n >= 16 && !w1[15] && !w2[15])
      check("both_same_cycle", m_both - s_both, 1);
    check_regs();
  endtask

  task automatic read_one(input logic [3:0] a, input logic [11:0] exp);
    @(negedge clk);
    rd_addr = a;
    @(posedge clk); #1;
    check("rd_data", {20'd0, rd_data}, {20'd0, exp});
  endtask

  task automatic sweep_shadow();
    for (int a = 0; a < 16; a++) exp_q.push_back(exp_shadow[a]);
    for (int a = 0; a < 16; a++) read_one(4'(a), exp_q.pop_front());
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_sticky = 2'b00;
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, sel;
    bit e1, e2;
    reset = 1'b1; DAC_SCLK = 1'b1; DAC1_SYNC = 1'b1; DAC2_SYNC = 1'b1;
    DAC1_DIN = 1'b0; DAC2_DIN = 1'b0; err_clr = 1'b0; rd_addr = 4'd0;
    model_reset();
    do_reset(4);
    #1;
    check("rst_wr_valid", {30'd0, wr2_valid, wr1_valid}, 32'd0);
    check("rst_pulses", {28'd0, ctrl_valid, err_pulse}, 32'd0);
    check_regs();
    read_one(4'h3, 12'h000);
    repeat (4) @(negedge clk);

    // link 1 data 0x3ABC with commit latency check
    run_frame(1, 16'h3ABC, 0, 16'h0, 16, 1);
    read_one(4'h3, 12'hABC);
    // link 2 data 0x5123
    run_frame(0, 16'h0, 1, 16'h5123, 16, 0);
    read_one(4'hD, 12'h123);
    // link 1 control 0x8FFF
    run_frame(1, 16'h8FFF, 0, 16'h0, 16, 0);
    sweep_shadow();
    // link 1 truncated after 10 bits, then clear
    run_frame(1, 16'h4321, 0, 16'h0, 10, 0);
    pulse_clr();
    check("sticky_cleared", {30'd0, err_sticky}, 32'd0);
    // link 2 overrun: 18 edges on 0x7055
    run_frame(0, 16'h0, 1, 16'h7055, 18, 0);
    read_one(4'hF, 12'h055);
    pulse_clr();
    // both links together
    run_frame(1, 16'h1111, 1, 16'h1222, 16, 0);
    read_one(4'h1, 12'h111);
    read_one(4'h9, 12'h222);
    // silent abort: SYNC pulse with no edges
    run_frame(1, 16'h0, 0, 16'h0, 0, 0);

    // reset mid-frame with SYNC held low through and after reset
    begin
      int s_wr1, s_e1;
      s_wr1 = m_wr1; s_e1 = m_err1;
      @(negedge clk);
      DAC1_SYNC = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 8; i++) sclk_bit(1'($urandom), 1'b0, 0);
      do_reset(3);
      #1;
      check("mid_rst_regs_cnt", {16'd0, frame_cnt1}, 32'd0);
      for (int i = 0; i < 8; i++) sclk_bit(1'($urandom), 1'b0, 0);
      repeat (2) @(negedge clk);
      DAC1_SYNC = 1'b1;
      repeat (6) @(negedge clk);
      check("mid_rst_no_commit", m_wr1 - s_wr1, 0);
      check("mid_rst_no_err", m_err1 - s_e1, 0);
      check_regs();
      sweep_shadow();
      run_frame(1, 16'h2004, 0, 16'h0, 16, 0);
      read_one(4'h2, 12'h004);
    end

    // randomized frames
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 19);
      n = (sel < 14) ? 16 : (sel < 17) ? $urandom_range(1, 15) : (sel < 19) ? $urandom_range(17, 18) : 0;
      e1 = 1'($urandom); e2 = 1'($urandom);
      if (!e1 && !e2) e1 = 1'b1;
      if ($urandom_range(0, 3) == 0) pulse_clr();
      run_frame(e1, 16'($urandom), e2, 16'($urandom), n, 0);
      if (it % 10 == 9) sweep_shadow();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/lcms_dac_serial_rx.md
Name: lcms_dac_serial_rx

Overview:
Receive-side model of the two DAC serial links: shared DAC_SCLK, per-DAC SYNC and DIN.
- Oversamples the links on dac_sm_clk and decodes 16-bit frames.
- Writes DAC words into a 16-entry shadow register file and reports control words and framing errors.
- Used in loopback verification and board self-check to read back the programmed bias/reference values.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on every serial input; latency scales with it.
- FRAME_BITS, 16, bits per frame; must be 16 for the decode below.

Ports:
- dac_sm_clk  in  1  system clock; at least 4x DAC_SCLK frequency.
- reset  in  1  synchronous, active-high.
- DAC_SCLK  in  1  serial clock shared by both links; data valid on its falling edge.
- DAC1_SYNC  in  1  link 1 frame strobe, active-low.
- DAC1_DIN  in  1  link 1 data, MSB first.
- DAC2_SYNC  in  1  link 2 frame strobe, active-low.
- DAC2_DIN  in  1  link 2 data, MSB first.
- wr1_valid  out  1  one-cycle pulse: link 1 data word committed.
- wr2_valid  out  1  one-cycle pulse: link 2 data word committed.
- wr_ch  out  6  {link2 ch[2:0], link1 ch[2:0]} of the last commit on each link.
- wr_data1  out  12  link 1 last committed data.
- wr_data2  out  12  link 2 last committed data.
- ctrl_valid  out  2  per-link pulse: control word received (bit15=1).
- ctrl_word  out  15  bits[14:0] of the most recent control word (link 1 wins a same-cycle tie).
- err_pulse  out  2  per-link one-cycle framing-error pulse.
- err_sticky  out  2  per-link sticky error flag.
- err_clr  in  1  clears err_sticky.
- rd_addr  in  4  shadow read address: {link(0=DAC1,1=DAC2), ch[2:0]}.
- rd_data  out  12  registered shadow readback.
- frame_cnt1  out  16  committed link 1 frames (data+control); wraps 0xFFFF->0.
- frame_cnt2  out  16  committed link 2 frames (data+control); wraps 0xFFFF->0.

Behaviour:
Input synchronization
- Each serial input passes through SYNC_STAGES flops.
- Reset values: SCLK=1, SYNC=1, DIN=0.
- sclk_fall = synced SCLK was 1 last cycle and is 0 now; sync_rise and sync_fall are detected the same way.

Per-link FSM
- WAIT_HIGH: entered on reset. Go to IDLE once synced SYNC=1. Prevents spurious frames when SYNC is low across reset.
- IDLE: on sync_fall, clear shift register and bit count, go to SHIFT.
- SHIFT: on each sclk_fall, shift in DIN and increment count.
  - On the 16th bit, commit and go to DONE.
  - sync_rise with count 1..15: err_pulse, set sticky, discard, go to IDLE.
  - sync_rise with count 0: silent abort to IDLE.
- DONE: further sclk_falls set an overrun flag.
  - On sync_rise, go to IDLE; raise err_pulse and set sticky if overrun.
  - The committed word stands.

Commit and decode
- Frame bit15=0: data word. ch=bits[14:12], data=bits[11:0]; shadow[{link,ch}] <= data; wrN_valid pulses.
- Frame bit15=1: control word. ctrl_valid[N] pulses; ctrl_word updated; shadow untouched.
- frame_cntN increments on every commit.
- Latency: commit outputs visible after the (SYNC_STAGES+1)th rising edge of dac_sm_clk that samples the 16th raw SCLK low.

Simultaneous events
- Both links committing in the same cycle: both shadow writes occur (addresses are disjoint), both strobes pulse.
- err_clr coincident with a new error: the error wins, sticky=1.

Readback
- rd_data <= shadow[rd_addr] every cycle (1-cycle latency).
- Read and write to the same address in one cycle returns the old value.

Reset
- Every output, the shadow file, counters, and sticky flags go to 0.
- An in-flight frame is discarded; the FSM returns to WAIT_HIGH.

Test Plan:
- Link 1 frame 0x3ABC, 16 clean SCLK edges -> wr1_valid one pulse; wr_ch[2:0]=3; wr_data1=0xABC; frame_cnt1=1; then rd_addr=0x3 -> rd_data=0xABC next cycle.
- Link 2 frame 0x5123 -> wr2_valid; rd_addr=0xD -> 0x123. Link 1 control 0x8FFF -> ctrl_valid=01, ctrl_word=0x0FFF; shadow unchanged; frame_cnt1 increments.
- Link 1 SYNC rises after 10 bits -> err_pulse=01, err_sticky=01, no wr1_valid; err_clr -> sticky=00.
- Link 2 18 falling edges on 0x7055 + 2 extra bits -> commit ch7 data 0x055 at 16th edge; err_pulse=10 at SYNC rise; shadow[0xF]=0x055.
- Both links send concurrently (0x1111 on link 1, 0x1222 on link 2) -> wr1_valid and wr2_valid in the same cycle; shadow[0x1]=0x111, shadow[0x9]=0x222.
- reset asserted after 8 bits with SYNC held low, released, SYNC stays low with 8 more edges -> no commit, no error; next full frame 0x2004 after SYNC high decodes correctly.
